// File: rtl/fuel_pump_pkg.sv
// Shared constants and state encodings for the fuel-pump blocks
// (fill controller, display and price stages).
package fuel_pump_pkg;

  localparam int VOL_W           = 16;
  localparam int CLK_HZ_DEF      = 1_000_000;
  localparam int DEBOUNCE_DEF    = 20_000;
  localparam int STALL_LIMIT_DEF = 2_000_000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_PUMPING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_DONE    = 3'd4,
    ST_FAULT   = 3'd5
  } fill_state_e;

  // Volume still to pump; clamps at zero once the target is met or overshot.
  function automatic logic [VOL_W-1:0] sat_sub(input logic [VOL_W-1:0] a,
                                               input logic [VOL_W-1:0] b);
    return (b >= a) ? '0 : a - b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a
// one-cycle pulse when a press (rising level) is accepted.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          r_pulse;
  logic          w_accept;

  // The synced level must differ from the accepted level for the full window.
  assign w_accept = (r_sync[1] != r_stable) && (r_cnt == LAST);

  // Synchronize, time the stable interval and emit the press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_pulse  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_pulse <= w_accept && r_sync[1];
      if (r_sync[1] == r_stable || w_accept) r_cnt <= '0;
      else                                   r_cnt <= r_cnt + 1'b1;
      if (w_accept) r_stable <= r_sync[1];
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/pump_fill_controller.sv
// Metered fill controller: clears the volume calculator, runs the pump relay
// until the latched target is reached, with pause/resume and dry-tank /
// stalled-flow faults.
module pump_fill_controller
  import fuel_pump_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int STALL_LIMIT     = STALL_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_btn,
  input  logic             stop_btn,
  input  logic             tank_empty,
  input  logic [VOL_W-1:0] target_volume,
  input  logic [VOL_W-1:0] pumped_volume,
  output logic             relay_auto,
  output logic             clear_volume,
  output logic [VOL_W-1:0] remaining_volume,
  output logic [2:0]       state_o,
  output logic             done_led,
  output logic             fault_led
);

  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);

  fill_state_e      r_state, w_next;
  logic             w_start, w_stop, w_tank, w_stall, w_latch;
  logic [1:0]       r_tank_sync;
  logic             r_settle;
  logic [VOL_W-1:0] r_target, w_target_nxt, r_prev_vol, r_remaining;
  logic [SW-1:0]    r_stall_cnt;
  logic             r_relay, r_clear, r_done, r_fault;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk(clk), .rst_n(rst_n), .i_btn(start_btn), .o_pulse(w_start));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop_db (
    .clk(clk), .rst_n(rst_n), .i_btn(stop_btn), .o_pulse(w_stop));

  assign w_tank       = r_tank_sync[1];
  assign w_stall      = (r_stall_cnt >= STALL_LAST);
  assign w_target_nxt = w_latch ? target_volume : r_target;

  // Next state; stop beats faults, faults beat start, start beats completion.
  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_stop) w_next = ST_IDLE;
        else if (w_start) begin
          w_latch = 1'b1;
          if (target_volume == '0) w_next = ST_DONE;
          else if (w_tank)         w_next = ST_FAULT;
          else                     w_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (w_stop)        w_next = ST_IDLE;
        else if (w_tank)   w_next = ST_FAULT;
        else if (r_settle) w_next = ST_PUMPING;
      end
      ST_PUMPING: begin
        if (w_stop)                       w_next = ST_PAUSED;
        else if (w_tank || w_stall)       w_next = ST_FAULT;
        else if (pumped_volume >= r_target) w_next = ST_DONE;
      end
      ST_PAUSED: begin
        // Dry tank only matters once the operator tries to resume.
        if (w_stop)       w_next = ST_IDLE;
        else if (w_start) w_next = w_tank ? ST_FAULT : ST_PUMPING;
      end
      ST_FAULT: if (w_stop) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State, target latch, stall timer and registered outputs; outputs follow
  // the next state so the relay drops in the same cycle DONE/FAULT appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_tank_sync <= '0;
      r_settle    <= 1'b0;
      r_target    <= '0;
      r_prev_vol  <= '0;
      r_stall_cnt <= '0;
      r_remaining <= '0;
      r_relay     <= 1'b0;
      r_clear     <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_tank_sync <= {r_tank_sync[0], tank_empty};
      r_settle    <= (r_state == ST_CLEAR) && (w_next == ST_CLEAR);
      r_target    <= w_target_nxt;
      r_prev_vol  <= pumped_volume;
      if (r_state != ST_PUMPING || pumped_volume != r_prev_vol) r_stall_cnt <= '0;
      else if (!w_stall)                                        r_stall_cnt <= r_stall_cnt + 1'b1;
      r_remaining <= (w_next == ST_IDLE) ? '0 : sat_sub(w_target_nxt, pumped_volume);
      r_relay     <= (w_next == ST_PUMPING);
      r_clear     <= (w_next == ST_CLEAR) && (r_state != ST_CLEAR);
      r_done      <= (w_next == ST_DONE);
      r_fault     <= (w_next == ST_FAULT);
    end
  end

  assign relay_auto       = r_relay;
  assign clear_volume     = r_clear;
  assign remaining_volume = r_remaining;
  assign state_o          = r_state;
  assign done_led         = r_done;
  assign fault_led        = r_fault;

endmodule
